// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// state enum, opcode/funct values, ALU and mux select codes.
package mips_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET     = 5'd0,
    S_FETCH     = 5'd1,
    S_DECODE    = 5'd2,
    S_EXEC_R    = 5'd3,
    S_WB_R      = 5'd4,
    S_EXEC_I    = 5'd5,
    S_WB_I      = 5'd6,
    S_MEM_ADDR  = 5'd7,
    S_MEM_READ  = 5'd8,
    S_MEM_WRITE = 5'd9,
    S_WB_LOAD   = 5'd10,
    S_BRANCH    = 5'd11,
    S_JUMP      = 5'd12,
    S_ILLEGAL   = 5'd13,
    S_EXC_EPC   = 5'd14,
    S_EXC_VEC   = 5'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_CMP = 3'b111;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write_cond;
    logic       iord;
    logic       wr;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sel;
    logic [1:0] pc_source;
    logic       pc_load;
    logic       ir_load;
    logic       a_load;
    logic       b_load;
    logic       mdr_load;
    logic       aluout_load;
    logic       rst;
  } ctrl_t;

  function automatic logic funct_ok(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) || (fn == FN_XOR);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_XOR:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that stretches FETCH and MEM_READ over W+1 cycles.
// Loaded with W on state entry; o_zero marks the final cycle.
module mem_wait_counter #(
  parameter int W = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero,
  output logic o_one
);

  logic [2:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)                        r_cnt <= '0;
    else if (i_load)                  r_cnt <= 3'(W);
    else if (i_dec && r_cnt != 3'd0)  r_cnt <= r_cnt - 3'd1;
  end

  assign o_zero = (r_cnt == 3'd0);
  assign o_one  = (r_cnt == 3'd1);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath.
// Optional exception path (EPC/Cause, overflow trap) enabled by CTRL_EXC_EN.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int         MEM_WAIT_CYCLES = 1,
  parameter logic [1:0] EXC_VECTOR_SEL  = 2'b11
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       ALU_zero,
  input  logic       ALU_overflow,
  input  logic       ALU_neg,
  input  logic       ALU_eq,
  input  logic       ALU_gt,
  input  logic       ALU_lt,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       wr,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_sel,
  output logic [1:0] PCSource,
  output logic       PC_load,
  output logic       IR_load,
  output logic       A_load,
  output logic       B_load,
  output logic       MDR_load,
  output logic       ALUOut_load,
  output logic       RegReset,
  output logic       PC_reset,
  output logic       IR_reset,
  output logic       A_reset,
  output logic       B_reset,
  output logic       MDR_reset,
  output logic       ALUOut_reset,
`ifdef CTRL_EXC_EN
  output logic       EPC_load,
  output logic       Cause,
`endif
  output logic [4:0] State
);

  state_t r_state, w_nxt;
  ctrl_t  r_ctrl;
  logic   r_bne;
  logic   w_load, w_dec, w_zero, w_one, w_nxt_last, w_pc_load;
  logic   w_unused;

`ifdef CTRL_EXC_EN
  logic r_epc_load, r_cause;
  assign w_unused = ^{ALU_zero, ALU_neg, ALU_gt, ALU_lt};
`else
  assign w_unused = ^{ALU_zero, ALU_overflow, ALU_neg, ALU_gt, ALU_lt};
`endif

  mem_wait_counter #(.W(MEM_WAIT_CYCLES)) u_wait (
    .i_clk  (Clk),
    .i_rst  (reset),
    .i_load (w_load),
    .i_dec  (w_dec),
    .o_zero (w_zero),
    .o_one  (w_one)
  );

  function automatic ctrl_t decode(input state_t s, input logic last, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_RESET:   c.rst = 1'b1;
      S_FETCH: begin
        c.alu_src_b = SRCB_FOUR;
        c.alu_sel   = ALU_ADD;
        c.pc_source = PCS_ALU;
        c.ir_load   = last;
        c.pc_load   = last;
      end
      S_DECODE: begin
        c.a_load      = 1'b1;
        c.b_load      = 1'b1;
        c.alu_src_b   = SRCB_IMM_SH;
        c.alu_sel     = ALU_ADD;
        c.aluout_load = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_B;
        c.alu_sel     = funct_alu(fn);
        c.aluout_load = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_IMM;
        c.alu_sel     = ALU_ADD;
        c.aluout_load = 1'b1;
      end
      S_WB_R: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_WB_I:    c.reg_write = 1'b1;
      S_MEM_READ: begin
        c.iord     = 1'b1;
        c.mdr_load = last;
      end
      S_WB_LOAD: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        c.iord = 1'b1;
        c.wr   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_sel       = ALU_CMP;
        c.pc_source     = PCS_ALUOUT;
        c.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        c.pc_source = PCS_JUMP;
        c.pc_load   = 1'b1;
      end
      S_EXC_EPC: begin
        c.alu_src_b = SRCB_FOUR;
        c.alu_sel   = ALU_SUB;
      end
      S_EXC_VEC: begin
        c.pc_source = EXC_VECTOR_SEL;
        c.pc_load   = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_RESET:  w_nxt = S_FETCH;
      S_FETCH:  if (w_zero) w_nxt = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     w_nxt = funct_ok(Funct) ? S_EXEC_R : S_ILLEGAL;
          OP_ADDI:      w_nxt = S_EXEC_I;
          OP_LW, OP_SW: w_nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE: w_nxt = S_BRANCH;
          OP_J:         w_nxt = S_JUMP;
          default:      w_nxt = S_ILLEGAL;
        endcase
      end
`ifdef CTRL_EXC_EN
      S_EXEC_R:  w_nxt = (ALU_overflow && (Funct == FN_ADD || Funct == FN_SUB)) ? S_EXC_EPC : S_WB_R;
      S_EXEC_I:  w_nxt = (ALU_overflow && Opcode == OP_ADDI) ? S_EXC_EPC : S_WB_I;
      S_ILLEGAL: w_nxt = S_EXC_EPC;
`else
      S_EXEC_R:  w_nxt = S_WB_R;
      S_EXEC_I:  w_nxt = S_WB_I;
      S_ILLEGAL: w_nxt = S_FETCH;
`endif
      S_MEM_ADDR: w_nxt = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: if (w_zero) w_nxt = S_WB_LOAD;
      S_EXC_EPC:  w_nxt = S_EXC_VEC;
      default:    w_nxt = S_FETCH;
    endcase
    // Outputs are registered, so the final wait cycle is predicted one cycle ahead.
    w_load     = (w_nxt == S_FETCH || w_nxt == S_MEM_READ) && (w_nxt != r_state);
    w_dec      = (r_state == S_FETCH || r_state == S_MEM_READ) && !w_zero;
    w_nxt_last = w_load ? (MEM_WAIT_CYCLES == 0) : (w_dec && w_one);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state <= S_RESET;
      r_ctrl  <= decode(S_RESET, 1'b0, Funct);
      r_bne   <= 1'b0;
`ifdef CTRL_EXC_EN
      r_epc_load <= 1'b0;
      r_cause    <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;
      r_ctrl  <= decode(w_nxt, w_nxt_last, Funct);
      r_bne   <= (Opcode == OP_BNE);
`ifdef CTRL_EXC_EN
      r_epc_load <= (w_nxt == S_EXC_EPC);
      r_cause    <= (w_nxt == S_EXC_EPC) && (r_state != S_ILLEGAL);
`endif
    end
  end

  // The branch decision needs this cycle's compare result, so it bypasses the register.
  assign w_pc_load = r_ctrl.pc_load | (r_ctrl.pc_write_cond & (ALU_eq ^ r_bne));

  assign PCWrite      = w_pc_load;
  assign PC_load      = w_pc_load;
  assign PCWriteCond  = r_ctrl.pc_write_cond;
  assign IorD         = r_ctrl.iord;
  assign wr           = r_ctrl.wr;
  assign MemtoReg     = r_ctrl.mem_to_reg;
  assign RegDst       = r_ctrl.reg_dst;
  assign RegWrite     = r_ctrl.reg_write;
  assign ALUSrcA      = r_ctrl.alu_src_a;
  assign ALUSrcB      = r_ctrl.alu_src_b;
  assign ALU_sel      = r_ctrl.alu_sel;
  assign PCSource     = r_ctrl.pc_source;
  assign IR_load      = r_ctrl.ir_load;
  assign A_load       = r_ctrl.a_load;
  assign B_load       = r_ctrl.b_load;
  assign MDR_load     = r_ctrl.mdr_load;
  assign ALUOut_load  = r_ctrl.aluout_load;
  assign RegReset     = r_ctrl.rst;
  assign PC_reset     = r_ctrl.rst;
  assign IR_reset     = r_ctrl.rst;
  assign A_reset      = r_ctrl.rst;
  assign B_reset      = r_ctrl.rst;
  assign MDR_reset    = r_ctrl.rst;
  assign ALUOut_reset = r_ctrl.rst;
  assign State        = r_state;
`ifdef CTRL_EXC_EN
  assign EPC_load     = r_epc_load;
  assign Cause        = r_cause;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: two instances (memory wait 1 and 3) checked
// against an instruction-level model of the expected per-cycle control vector.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       wr;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sel;
    logic [1:0] pc_source;
    logic       pc_load;
    logic       ir_load;
    logic       a_load;
    logic       b_load;
    logic       mdr_load;
    logic       aluout_load;
    logic [6:0] rsts;
  } exp_t;

  localparam int P_RST = 0, P_F = 1, P_DEC = 2, P_EXR = 3, P_WBR = 4, P_EXI = 5, P_WBI = 6;
  localparam int P_MR = 7, P_WBL = 8, P_MW = 9, P_BR = 10, P_J = 11, P_NOP = 12;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Opcode = '0, Funct = '0;
  logic       ALU_zero = 0, ALU_overflow = 0, ALU_neg = 0, ALU_eq = 0, ALU_gt = 0, ALU_lt = 0;
  wire [27:0] ob [2];
  wire [4:0]  st [2];

  int   sel = 0;
  int   n_chk = 0, n_fail = 0;
  exp_t exp_q[$];
  exp_t seq[$];
  exp_t e_c, a_c;
  logic [5:0] ops [8];
  logic [5:0] fns [4];

  always #5 Clk = ~Clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mips_multicycle_ctrl #(.MEM_WAIT_CYCLES(k == 0 ? 1 : 3), .EXC_VECTOR_SEL(2'b11)) u_dut (
      .Clk(Clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
      .ALU_zero(ALU_zero), .ALU_overflow(ALU_overflow), .ALU_neg(ALU_neg),
      .ALU_eq(ALU_eq), .ALU_gt(ALU_gt), .ALU_lt(ALU_lt),
      .PCWrite(ob[k][27]), .PCWriteCond(ob[k][26]), .IorD(ob[k][25]), .wr(ob[k][24]),
      .MemtoReg(ob[k][23]), .RegDst(ob[k][22]), .RegWrite(ob[k][21]), .ALUSrcA(ob[k][20]),
      .ALUSrcB(ob[k][19:18]), .ALU_sel(ob[k][17:15]), .PCSource(ob[k][14:13]),
      .PC_load(ob[k][12]), .IR_load(ob[k][11]), .A_load(ob[k][10]), .B_load(ob[k][9]),
      .MDR_load(ob[k][8]), .ALUOut_load(ob[k][7]),
      .RegReset(ob[k][6]), .PC_reset(ob[k][5]), .IR_reset(ob[k][4]), .A_reset(ob[k][3]),
      .B_reset(ob[k][2]), .MDR_reset(ob[k][1]), .ALUOut_reset(ob[k][0]),
      .State(st[k])
    );
  end

  function automatic exp_t cur();
    return (sel == 0) ? ob[0] : ob[1];
  endfunction

  // Expected control vector for one cycle of a given instruction phase.
  function automatic exp_t mk(input int ph, input logic [2:0] alu, input bit flag);
    exp_t e;
    e = '0;
    case (ph)
      P_RST: e.rsts = 7'h7f;
      P_F:   begin e.alu_src_b = 2'b01; e.alu_sel = 3'b001;
                   e.ir_load = flag; e.pc_load = flag; e.pc_write = flag; end
      P_DEC: begin e.a_load = 1; e.b_load = 1; e.alu_src_b = 2'b11; e.alu_sel = 3'b001;
                   e.aluout_load = 1; end
      P_EXR: begin e.alu_src_a = 1; e.alu_sel = alu; e.aluout_load = 1; end
      P_WBR: begin e.reg_dst = 1; e.reg_write = 1; end
      P_EXI: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_sel = 3'b001; e.aluout_load = 1; end
      P_WBI: e.reg_write = 1;
      P_MR:  begin e.iord = 1; e.mdr_load = flag; end
      P_WBL: begin e.mem_to_reg = 1; e.reg_write = 1; end
      P_MW:  begin e.iord = 1; e.wr = 1; end
      P_BR:  begin e.alu_src_a = 1; e.alu_sel = 3'b111; e.pc_source = 2'b01;
                   e.pc_write_cond = 1; e.pc_load = flag; e.pc_write = flag; end
      P_J:   begin e.pc_source = 2'b10; e.pc_load = 1; e.pc_write = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic eq, input int w);
    logic [2:0] alu;
    seq.delete();
    for (int i = 0; i <= w; i++) seq.push_back(mk(P_F, 3'd0, i == w));
    seq.push_back(mk(P_DEC, 3'd0, 0));
    case (op)
      6'h00: begin
        alu = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : (fn == 6'h24) ? 3'd3 :
              (fn == 6'h26) ? 3'd6 : 3'd0;
        if (alu != 3'd0) begin
          seq.push_back(mk(P_EXR, alu, 0));
          seq.push_back(mk(P_WBR, 3'd0, 0));
        end else seq.push_back(mk(P_NOP, 3'd0, 0));
      end
      6'h08: begin seq.push_back(mk(P_EXI, 3'd0, 0)); seq.push_back(mk(P_WBI, 3'd0, 0)); end
      6'h23: begin
        seq.push_back(mk(P_EXI, 3'd0, 0));
        for (int i = 0; i <= w; i++) seq.push_back(mk(P_MR, 3'd0, i == w));
        seq.push_back(mk(P_WBL, 3'd0, 0));
      end
      6'h2B: begin seq.push_back(mk(P_EXI, 3'd0, 0)); seq.push_back(mk(P_MW, 3'd0, 0)); end
      6'h04: seq.push_back(mk(P_BR, 3'd0, eq));
      6'h05: seq.push_back(mk(P_BR, 3'd0, !eq));
      6'h02: seq.push_back(mk(P_J, 3'd0, 0));
      default: seq.push_back(mk(P_NOP, 3'd0, 0));
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() != 0) begin
      e_c = exp_q.pop_front();
      a_c = cur();
      n_chk++;
      if (a_c !== e_c) begin
        n_fail++;
        $display("FAIL cycle_outputs dut%0d t=%0t: got %h expected %h", sel, $time, a_c, e_c);
      end
    end
  end

  // Called at #1 into a cycle; starts one instruction whose first FETCH cycle is the current one.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                           input int probe, input int stop, output int n, output exp_t snap);
    int w, last;
    w = (sel == 0) ? 1 : 3;
    build(op, fn, eq, w);
    n = seq.size();
    snap = '0;
    last = (stop > 0) ? stop : n;
    Opcode = op; Funct = fn; ALU_eq = eq;
    {ALU_zero, ALU_overflow, ALU_neg, ALU_gt, ALU_lt} = 5'($urandom);
    for (int c = 1; c <= last; c++) begin
      exp_q.push_back(seq[c-1]);
      if (c == probe) snap = cur();
      if (c < last || stop == 0) begin @(posedge Clk); #1; end
    end
  endtask

  task automatic do_reset(input int ncyc, input int newsel);
    exp_t s;
    reset = 1'b1;
    @(posedge Clk); #1;
    sel = newsel;
    for (int c = 1; c <= ncyc; c++) begin
      exp_q.push_back(mk(P_RST, 3'd0, 0));
      if (c == 1) begin
        s = cur();
        chk("reset_state", 32'(st[sel]), 32'(S_RESET));
        chk("reset_all_resets", 32'(s.rsts), 32'h7f);
        chk("reset_regwrite", 32'(s.reg_write), 32'd0);
        chk("reset_wr", 32'(s.wr), 32'd0);
      end
      if (c < ncyc) begin @(posedge Clk); #1; end
    end
    reset = 1'b0;
    @(posedge Clk); #1;
    chk("fetch_after_reset", 32'(st[sel]), 32'(S_FETCH));
  endtask

  task automatic run_random(input int cnt);
    int n, idx;
    exp_t s;
    logic [5:0] op, fn;
    for (int i = 0; i < cnt; i++) begin
      idx = int'($urandom_range(8, 0));
      op  = (idx == 8) ? 6'($urandom) : ops[idx];
      idx = int'($urandom_range(5, 0));
      fn  = (idx >= 4) ? 6'($urandom) : fns[idx];
      run_instr(op, fn, 1'($urandom), 0, 0, n, s);
    end
  endtask

  initial begin
    int   n;
    exp_t s;
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h26};

    do_reset(2, 0);

    run_instr(6'h00, 6'h20, 1'b0, 5, 0, n, s);
    chk("add_latency", 32'(n), 32'd5);
    chk("add_regwrite_c5", 32'(s.reg_write), 32'd1);
    chk("add_regdst_c5", 32'(s.reg_dst), 32'd1);
    chk("add_next_fetch", 32'(st[sel]), 32'(S_FETCH));

    run_instr(6'h04, 6'h00, 1'b1, 4, 0, n, s);
    chk("beq_latency", 32'(n), 32'd4);
    chk("beq_taken_pcload", 32'(s.pc_load), 32'd1);
    chk("beq_pcsource", 32'(s.pc_source), 32'd1);
    run_instr(6'h04, 6'h00, 1'b0, 4, 0, n, s);
    chk("beq_not_taken_pcload", 32'(s.pc_load), 32'd0);
    run_instr(6'h05, 6'h00, 1'b0, 4, 0, n, s);
    chk("bne_taken_pcload", 32'(s.pc_load), 32'd1);

    run_instr(6'h02, 6'h00, 1'b0, 4, 0, n, s);
    chk("j_latency", 32'(n), 32'd4);
    chk("j_pcload", 32'(s.pc_load), 32'd1);
    chk("j_pcsource", 32'(s.pc_source), 32'd2);
    chk("j_no_writes", 32'({s.reg_write, s.wr}), 32'd0);

    run_instr(6'h3F, 6'h00, 1'b0, 4, 0, n, s);
    chk("illegal_latency", 32'(n), 32'd4);
    chk("illegal_no_writes", 32'({s.reg_write, s.wr, s.pc_load}), 32'd0);

    run_instr(6'h2B, 6'h00, 1'b0, 5, 0, n, s);
    chk("sw_latency", 32'(n), 32'd5);
    chk("sw_wr", 32'({s.wr, s.iord}), 32'h3);

    run_random(40);

    do_reset(2, 1);
    run_instr(6'h23, 6'h00, 1'b0, 10, 0, n, s);
    chk("lw_w3_latency", 32'(n), 32'd11);
    chk("lw_w3_mdr_last_read", 32'({s.iord, s.mdr_load}), 32'h3);

    run_instr(6'h23, 6'h00, 1'b0, 7, 8, n, s);
    chk("lw_w3_iord_first_read", 32'({s.iord, s.mdr_load}), 32'h2);
    do_reset(2, 1);

    run_random(30);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore control FSM for the multicycle MIPS datapath; sits directly upstream of the datapath and drives every mux select, register load/reset, memory write and ALU operation from opcode, funct and ALU flags. It sequences fetch, decode, execute, memory and write-back for a fixed instruction subset. Memory read latency is absorbed by an internal wait counter, so no handshake with memory is needed.

Parameters:
MEM_WAIT_CYCLES, 1, extra cycles (0..7) a memory read needs before data is stable; W below.
EXC_VECTOR_SEL, 2'b11, PCSource code selecting the exception vector (used only with CTRL_EXC_EN).

Ports:
Clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
Opcode  in  6  instruction bits 31:26 from IR
Funct  in  6  instruction bits 5:0 from IR
ALU_zero, ALU_overflow, ALU_neg, ALU_eq, ALU_gt, ALU_lt  in  1 each  ALU flags
PCWrite, PCWriteCond  out  1  PC_load alias / high in BRANCH state
IorD  out  1  0=PC, 1=ALUOut as memory address
wr  out  1  memory write
MemtoReg  out  1  0=ALUOut, 1=MDR to register file
RegDst  out  1  0=rt, 1=rd destination
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=4, 10=signext, 11=signext<<2
ALU_sel  out  3  001 add, 010 sub, 011 and, 110 xor, 111 compare
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump address
PC_load, IR_load, A_load, B_load, MDR_load, ALUOut_load  out  1 each  register loads
RegReset, PC_reset, IR_reset, A_reset, B_reset, MDR_reset, ALUOut_reset  out  1 each
State  out  5  current state encoding (debug)

Behaviour:
- reset sampled at Clk edge: state<=RESET, counter<=0. RESET state asserts all *_reset and RegReset, every other output 0; this is the reset value of all outputs. Next: FETCH.
- Unlisted outputs are 0 in every state.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_sel=001, PCSource=00. Stays W+1 cycles (counter loaded with W on entry, decrements). Only in last cycle: IR_load=1, PC_load=1. -> DECODE.
- DECODE: A_load, B_load, ALUSrcA=0, ALUSrcB=11, add, ALUOut_load (branch target). Dispatch on Opcode: 0x00 R, 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j, else ILLEGAL.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALU_sel from Funct (0x20 add, 0x22 sub, 0x24 and, 0x26 xor; other funct -> ILLEGAL), ALUOut_load -> WB_R: RegDst=1, MemtoReg=0, RegWrite -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, add, ALUOut_load -> WB_I: RegDst=0, MemtoReg=0, RegWrite -> FETCH.
- MEM_ADDR: as EXEC_I -> MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: IorD=1, W+1 cycles, MDR_load in last -> WB_LOAD: RegDst=0, MemtoReg=1, RegWrite -> FETCH.
- MEM_WRITE: IorD=1, wr=1, one cycle -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_sel=111, PCSource=01, PCWriteCond=1, PC_load = ALU_eq for beq, !ALU_eq for bne -> FETCH.
- JUMP: PCSource=10, PC_load -> FETCH.
- ILLEGAL: no writes, one cycle -> FETCH (without CTRL_EXC_EN).
- Latency (W=1): R/addi 5, lw 7, sw 5, beq/bne 4, j 4 cycles.
- reset mid-instruction: abandons instruction immediately; no write strobe in the reset cycle or after.
- PCWrite always equals PC_load.

Optional Feature:
CTRL_EXC_EN: adds outputs EPC_load (1) and Cause (1). ILLEGAL, or ALU_overflow in the cycle after EXEC_R/EXEC_I with add/sub/addi, go to EXC_EPC (ALUSrcA=0, ALUSrcB=01, ALU_sel=010, EPC_load, Cause=0 illegal/1 overflow) then EXC_VEC (PCSource=EXC_VECTOR_SEL, PC_load) -> FETCH; the faulting write-back is suppressed. Without the macro, overflow is ignored and ILLEGAL is a NOP.

Decomposition:
Package mips_ctrl_pkg: state enum, opcode and funct localparams, ALU_sel and PCSource/ALUSrcB codes. One sub-module: mem_wait_counter (load/decrement/zero flag) shared by FETCH and MEM_READ.

Test Plan:
- reset held 2 cycles mid-MEM_READ -> State=RESET, all *_reset=1, RegWrite=wr=0; FETCH on the cycle after release.
- add (Opcode 0x00, Funct 0x20), W=1 -> RegWrite=1, RegDst=1 exactly at cycle 5; next FETCH at cycle 6.
- lw (0x23), W=3 -> MDR_load at cycle 4+... FETCH 4 + DECODE + MEM_ADDR + MEM_READ 4 + WB = 11 cycles; IorD=1 throughout MEM_READ.
- beq (0x04) with ALU_eq=1 then 0 -> PC_load=1 with PCSource=01 in cycle 4; second run PC_load=0.
- j (0x02) -> PC_load=1, PCSource=10 at cycle 4; no RegWrite or wr.
- CTRL_EXC_EN, Opcode 0x3F -> EPC_load=1, Cause=0, then PC_load with PCSource=11; without macro, returns to FETCH with no writes.
